// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front-end: FSM states, redirect causes
// and the fixed instruction length.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_PRED = 2'd1,
        CAUSE_JUMP = 2'd2,
        CAUSE_EXC  = 2'd3
    } cause_e;

    localparam int unsigned ILEN_BYTES = 4;

endpackage

// File: rtl/fetch_redirect_arb.sv
// Priority selector for PC redirect sources (exception > jump > prediction);
// the chosen target is forced to word alignment.
module fetch_redirect_arb
    import fetch_pkg::*;
#(
    parameter int unsigned SIZE = 32
) (
    input  logic            exc_valid,
    input  logic [SIZE-1:0] mtvec_address,
    input  logic            jump_valid,
    input  logic [SIZE-1:0] jump_target,
    input  logic            pred_valid,
    input  logic [SIZE-1:0] pred_target,
    output logic            redir_valid,
    output logic [1:0]      redir_cause,
    output logic [SIZE-1:0] redir_target
);

    cause_e          cause;
    logic [SIZE-1:0] rawTarget;

    // Highest-priority valid source wins; low two bits are dropped.
    always_comb begin
        cause     = CAUSE_NONE;
        rawTarget = '0;
        if (exc_valid) begin
            cause     = CAUSE_EXC;
            rawTarget = mtvec_address;
        end else if (jump_valid) begin
            cause     = CAUSE_JUMP;
            rawTarget = jump_target;
        end else if (pred_valid) begin
            cause     = CAUSE_PRED;
            rawTarget = pred_target;
        end
        redir_valid  = (cause != CAUSE_NONE);
        redir_cause  = cause;
        redir_target = {rawTarget[SIZE-1:2], 2'b00};
    end

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage PC sequencer against a single-outstanding instruction memory port.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/kill performance counters.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned     SIZE     = 32,
    parameter logic [SIZE-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            exc_valid,
    input  logic [SIZE-1:0] mtvec_address,
    input  logic            jump_valid,
    input  logic [SIZE-1:0] jump_target,
    input  logic            pred_valid,
    input  logic [SIZE-1:0] pred_target,
    output logic            imem_req,
    output logic [SIZE-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [SIZE-1:0] imem_rdata,
    output logic            if_valid,
    output logic [SIZE-1:0] if_pc,
    output logic [SIZE-1:0] if_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_kill_cnt
`endif
);

    state_e          state_q, state_d;
    logic [SIZE-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic            ifValid_q, ifValid_d;
    logic [SIZE-1:0] ifPc_q, ifPc_d;
    logic [SIZE-1:0] ifInstr_q, ifInstr_d;

    logic            redirValid;
    logic [1:0]      redirCause;
    logic [SIZE-1:0] redirTarget;
    logic            redirect;

    fetch_redirect_arb #(.SIZE(SIZE)) u_arb (
        .exc_valid     (exc_valid),
        .mtvec_address (mtvec_address),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .pred_valid    (pred_valid),
        .pred_target   (pred_target),
        .redir_valid   (redirValid),
        .redir_cause   (redirCause),
        .redir_target  (redirTarget)
    );

    assign redirect = redirValid && (redirCause != CAUSE_NONE);

    // pc_q is the fetch address; while a kill is pending it doubles as the latched target.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_RST;
            pc_q      <= RESET_PC;
            kill_q    <= 1'b0;
            ifValid_q <= 1'b0;
            ifPc_q    <= '0;
            ifInstr_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            kill_q    <= kill_d;
            ifValid_q <= ifValid_d;
            ifPc_q    <= ifPc_d;
            ifInstr_q <= ifInstr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        kill_d    = kill_q;
        ifValid_d = ifValid_q;
        ifPc_d    = ifPc_q;
        ifInstr_d = ifInstr_q;
        imem_req  = 1'b0;
        case (state_q)
            S_RST: state_d = S_REQ;
            S_REQ: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pc_d = redirTarget;
                    if (imem_gnt) begin
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d = redirTarget;
                end
                // The granted request must still drain its one response before refetching.
                if (imem_rvalid) begin
                    if (kill_q || redirect) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        ifValid_d = 1'b1;
                        ifPc_d    = pc_q;
                        ifInstr_d = imem_rdata;
                        state_d   = S_HOLD;
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    ifValid_d = 1'b0;
                    pc_d      = redirTarget;
                    state_d   = S_REQ;
                end else if (!stall) begin
                    ifValid_d = 1'b0;
                    pc_d      = pc_q + SIZE'(ILEN_BYTES);
                    state_d   = S_REQ;
                end
            end
            default: state_d = S_RST;
        endcase
    end

    assign imem_addr = pc_q;
    assign if_valid  = ifValid_q;
    assign if_pc     = ifPc_q;
    assign if_instr  = ifInstr_q;

`ifdef FETCH_PERF_CNT_EN
    logic        consumed;
    logic        discarded;
    logic [31:0] fetchCnt_q;
    logic [31:0] killCnt_q;

    // Discards cover killed responses and held instructions dropped by a redirect.
    assign consumed  = (state_q == S_HOLD) && !redirect && !stall;
    assign discarded = ((state_q == S_WAIT) && imem_rvalid && (kill_q || redirect)) ||
                       ((state_q == S_HOLD) && redirect);

    always_ff @(posedge clk) begin
        if (reset) begin
            fetchCnt_q <= '0;
            killCnt_q  <= '0;
        end else begin
            if (consumed && (fetchCnt_q != '1)) begin
                fetchCnt_q <= fetchCnt_q + 32'd1;
            end
            if (discarded && (killCnt_q != '1)) begin
                killCnt_q <= killCnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetchCnt_q;
    assign perf_kill_cnt  = killCnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: sequential fetch, stall hold, redirect
// priority and kill handling, reset abort and PC wrap.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        exc_valid;
    logic [31:0] mtvec_address;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        pred_valid;
    logic [31:0] pred_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_kill_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(.SIZE(32), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .exc_valid     (exc_valid),
        .mtvec_address (mtvec_address),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .pred_valid    (pred_valid),
        .pred_target   (pred_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_kill_cnt (perf_kill_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic gnt, input logic rvalid,
                                 input logic [31:0] rdata, input logic stl);
        imem_gnt    = gnt;
        imem_rvalid = rvalid;
        imem_rdata  = rdata;
        stall       = stl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkFetchOut(input string tag, input logic v,
                                 input logic [31:0] pc, input logic [31:0] instr);
        checkOutput({tag, "_valid"}, {31'd0, if_valid}, {31'd0, v});
        checkOutput({tag, "_pc"},    if_pc,    pc);
        checkOutput({tag, "_instr"}, if_instr, instr);
    endtask

    initial begin
        reset         = 1'b1;
        exc_valid     = 1'b0;
        jump_valid    = 1'b0;
        pred_valid    = 1'b0;
        mtvec_address = '0;
        jump_target   = '0;
        pred_target   = '0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();

        // Reset state
        checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
        checkOutput("rst_addr", imem_addr, 32'h0);
        checkFetchOut("rst", 1'b0, 32'h0, 32'h0);

        // Sequential fetch, gnt every cycle, rvalid one cycle after gnt
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            checkOutput("seq_req", {31'd0, imem_req}, 32'd1);
            checkOutput("seq_addr", imem_addr, 32'(4 * i));
            checkOutput("seq_vlo", {31'd0, if_valid}, 32'd0);
            tick();
            checkOutput("seq_wait_req", {31'd0, imem_req}, 32'd0);
            checkOutput("seq_wait_vlo", {31'd0, if_valid}, 32'd0);
            applyStimulus(1'b1, 1'b1, 32'h1000 + 32'(i), 1'b0);
            tick();
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
            checkFetchOut("seq_hold", 1'b1, 32'(4 * i), 32'h1000 + 32'(i));
            tick();
        end

        // Stall in S_HOLD for 5 cycles
        checkOutput("stall_addr0", imem_addr, 32'hC);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        for (int j = 0; j < 5; j++) begin
            checkFetchOut("stall_hold", 1'b1, 32'hC, 32'h0000_0013);
            checkOutput("stall_req", {31'd0, imem_req}, 32'd0);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("stall_resume_addr", imem_addr, 32'h10);
        checkOutput("stall_resume_req", {31'd0, imem_req}, 32'd1);
        checkOutput("stall_resume_vlo", {31'd0, if_valid}, 32'd0);

        // All three redirects together in S_WAIT: exception wins
        tick();
        jump_valid    = 1'b1;
        jump_target   = 32'h100;
        pred_valid    = 1'b1;
        pred_target   = 32'h200;
        exc_valid     = 1'b1;
        mtvec_address = 32'h80;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        jump_valid = 1'b0;
        pred_valid = 1'b0;
        exc_valid  = 1'b0;
        checkOutput("prio_wait_req", {31'd0, imem_req}, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("prio_addr", imem_addr, 32'h80);
        checkOutput("prio_req", {31'd0, imem_req}, 32'd1);
        checkFetchOut("prio_drop", 1'b0, 32'hC, 32'h0000_0013);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0000_0022, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkFetchOut("prio_fetch", 1'b1, 32'h80, 32'h0000_0022);

        // Unaligned jump in S_HOLD under stall
        jump_valid  = 1'b1;
        jump_target = 32'h103;
        tick();
        jump_valid = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("jhold_vlo", {31'd0, if_valid}, 32'd0);
        checkOutput("jhold_addr", imem_addr, 32'h100);
        checkOutput("jhold_req", {31'd0, imem_req}, 32'd1);

        // Prediction in S_REQ without gnt switches the address
        pred_valid  = 1'b1;
        pred_target = 32'h204;
        tick();
        pred_valid = 1'b0;
        checkOutput("preq_addr", imem_addr, 32'h204);
        checkOutput("preq_req", {31'd0, imem_req}, 32'd1);

        // Prediction in the gnt cycle kills the granted fetch
        pred_valid  = 1'b1;
        pred_target = 32'h300;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        pred_valid = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h0000_0055, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("pgnt_addr", imem_addr, 32'h300);
        checkOutput("pgnt_vlo", {31'd0, if_valid}, 32'd0);
        checkOutput("pgnt_instr", if_instr, 32'h0000_0022);

        // Reset during S_WAIT with a stale response afterwards
        tick();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        reset = 1'b0;
        checkOutput("rwait_req", {31'd0, imem_req}, 32'd0);
        checkOutput("rwait_addr", imem_addr, 32'h0);
        checkFetchOut("rwait", 1'b0, 32'h0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0000_0BAD, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("stale_addr", imem_addr, 32'h0);
        checkOutput("stale_req", {31'd0, imem_req}, 32'd1);
        checkFetchOut("stale", 1'b0, 32'h0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0000_0033, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkFetchOut("restart", 1'b1, 32'h0, 32'h0000_0033);

        // PC wrap from 0xFFFFFFFC
        jump_valid  = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        tick();
        jump_valid = 1'b0;
        checkOutput("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0000_0044, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkFetchOut("wrap_hold", 1'b1, 32'hFFFF_FFFC, 32'h0000_0044);
        tick();
        checkOutput("wrap_addr", imem_addr, 32'h0);
        checkOutput("wrap_req", {31'd0, imem_req}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
